// File: rtl/mem_resp_delay_pipe.sv
// Elastic delay pipeline for memory read responses with flush, bubble
// collapsing and an independent fixed-latency stall sideband.
module mem_resp_delay_pipe #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 2,
  parameter int STALL_DEPTH = 1,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_req,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_req,
  input  logic              out_ready,
  input  logic              stall_in,
  output logic              stall_out,
  output logic [CNT_W-1:0]  occupancy
);

  if (DEPTH < 1 || STALL_DEPTH < 1) begin : g_bad_param
    $error("mem_resp_delay_pipe: DEPTH and STALL_DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]       v_q, v_d;
  logic [DEPTH-1:0]       req_q, req_d;
  logic [DATA_W-1:0]      data_q [DEPTH];
  logic [DATA_W-1:0]      data_d [DEPTH];
  logic [DEPTH-1:0]       adv;
  logic [STALL_DEPTH-1:0] stall_q, stall_d;
  logic                   accept;

  // adv[i]: stage i may hand its content on this cycle
  always_comb begin
    logic acc;
    adv = '0;
    acc = out_ready | ~v_q[DEPTH-1];
    adv[DEPTH-1] = acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc = acc | ~v_q[i+1];
      adv[i] = acc;
    end
  end

  assign in_ready = ~v_q[0] | adv[0];
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    v_d    = v_q;
    req_d  = req_q;
    data_d = data_q;
    if (in_ready) begin
      v_d[0] = accept;
      if (accept) begin
        data_d[0] = in_data;
        req_d[0]  = in_req;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          data_d[i] = data_q[i-1];
          req_d[i]  = req_q[i-1];
        end
      end
    end
    if (flush) v_d = '0;
  end

  always_comb begin
    stall_d    = stall_q;
    stall_d[0] = stall_in;
    for (int i = 1; i < STALL_DEPTH; i++) begin
      stall_d[i] = stall_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      req_q   <= '0;
      stall_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      req_q   <= req_d;
      stall_q <= stall_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(v_q[i]);
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_req   = req_q[DEPTH-1];
  assign stall_out = stall_q[STALL_DEPTH-1];

endmodule

// File: tb/tb_mem_resp_delay_pipe.sv
// Bench for mem_resp_delay_pipe: per-cycle vector table plus a data
// scoreboard, with DEPTH=3 and STALL_DEPTH=2.
module tb_mem_resp_delay_pipe;

  localparam int DW = 64;
  localparam int D  = 3;
  localparam int SD = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_req;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          out_ready;
  logic          stall_in;
  logic          stall_out;
  logic [CW-1:0] occupancy;

  mem_resp_delay_pipe #(
    .DATA_W(DW), .DEPTH(D), .STALL_DEPTH(SD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_req(in_req),
    .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_req(out_req),
    .out_ready(out_ready), .stall_in(stall_in), .stall_out(stall_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       st;
    logic       eir;
    logic       eov;
    logic [1:0] eocc;
    logic       est;
  } vec_t;

  vec_t        vecs[$];
  logic [64:0] sb[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  int          cyc    = 0;

  function automatic logic [63:0] dat(input logic [7:0] id);
    return {32'hDEAD_BEEF, 24'h0, id};
  endfunction

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  task automatic add(input logic iv, input logic [7:0] id,
                     input logic ordy, input logic fl, input logic st,
                     input logic eir, input logic eov,
                     input logic [1:0] eocc, input logic est);
    vecs.push_back('{iv, id, ordy, fl, st, eir, eov, eocc, est});
  endtask

  task automatic drive(input logic iv, input logic [7:0] id,
                       input logic ordy, input logic fl, input logic st);
    in_valid  = iv;
    in_data   = iv ? dat(id) : 64'h0;
    in_req    = id[0];
    out_ready = ordy;
    flush     = fl;
    stall_in  = st;
  endtask

  initial begin
    // latency + back-to-back stream, stall pulse at c5
    add(1, 8'h01, 1, 0, 0, 1, 0, 0, 0);
    add(1, 8'h02, 1, 0, 0, 1, 0, 1, 0);
    add(1, 8'h03, 1, 0, 0, 1, 0, 2, 0);
    add(1, 8'h04, 1, 0, 0, 1, 1, 3, 0);
    add(1, 8'h05, 1, 0, 0, 1, 1, 3, 0);
    add(1, 8'h06, 1, 0, 1, 1, 1, 3, 0);
    add(1, 8'h07, 1, 0, 0, 1, 1, 3, 0);
    add(1, 8'h08, 1, 0, 0, 1, 1, 3, 1);
    add(0, 8'h00, 1, 0, 0, 1, 1, 3, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // backpressure: A,B,C fill, D blocked until out_ready
    add(1, 8'h0A, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h0B, 0, 0, 0, 1, 0, 1, 0);
    add(1, 8'h0C, 0, 0, 0, 1, 0, 2, 0);
    add(1, 8'h0D, 0, 0, 0, 0, 1, 3, 0);
    add(1, 8'h0D, 0, 0, 0, 0, 1, 3, 0);
    add(1, 8'h0D, 1, 0, 0, 1, 1, 3, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 3, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // bubble collapse: E, gap, F, held
    add(1, 8'h0E, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 1, 0);
    add(1, 8'h0F, 0, 0, 0, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 2, 0);
    add(0, 8'h00, 1, 0, 0, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // flush with three entries, head delivered
    add(1, 8'h11, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h12, 0, 0, 0, 1, 0, 1, 0);
    add(1, 8'h13, 0, 0, 0, 1, 0, 2, 0);
    add(1, 8'h14, 1, 1, 0, 1, 1, 3, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // stall pulse during flush with out_ready low
    add(0, 8'h00, 0, 1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);

    rst = 1'b1;
    drive(1, 8'h55, 1, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_out_data", 65'(out_data), 65'd0);
    chk("rst_stall_out", 65'(stall_out), 65'd0);
    chk("rst_occupancy", 65'(occupancy), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v   = vecs[i];
      cyc = i;
      drive(v.iv, v.id, v.ordy, v.fl, v.st);
      #1;
      chk("in_ready", 65'(in_ready), 65'(v.eir));
      chk("out_valid", 65'(out_valid), 65'(v.eov));
      chk("occupancy", 65'(occupancy), 65'(v.eocc));
      chk("stall_out", 65'(stall_out), 65'(v.est));
      if (v.eov) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL sb_underflow cyc=%0d got=out_valid want=empty",
                   cyc);
        end else begin
          chk("out_data_req", {out_req, out_data}, sb[0]);
          if (v.ordy) void'(sb.pop_front());
        end
      end
      if (v.fl) sb.delete();
      if (v.iv && v.eir && !v.fl) sb.push_back({v.id[0], dat(v.id)});
      @(negedge clk);
    end
    chk("sb_empty", 65'(sb.size()), 65'd0);

    // mid-operation reset drops in-flight entries
    cyc = 100;
    drive(1, 8'h21, 1, 0, 0);
    @(negedge clk);
    cyc = 101;
    drive(1, 8'h22, 1, 0, 0);
    #1 chk("mr_occ1", 65'(occupancy), 65'd1);
    @(negedge clk);
    cyc = 102;
    rst = 1'b1;
    drive(1, 8'h23, 1, 0, 0);
    #1 chk("mr_occ2", 65'(occupancy), 65'd2);
    @(negedge clk);
    cyc = 103;
    rst = 1'b0;
    drive(0, 8'h00, 1, 0, 0);
    #1;
    chk("mr_out_valid", 65'(out_valid), 65'd0);
    chk("mr_occupancy", 65'(occupancy), 65'd0);
    chk("mr_out_data", 65'(out_data), 65'd0);
    @(negedge clk);
    cyc = 104;
    #1;
    chk("mr_out_valid2", 65'(out_valid), 65'd0);
    chk("mr_occupancy2", 65'(occupancy), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
